decode_stage_reg: RTL

DECODE_STAGE_REG -- requirements
Module: decode_stage_reg

---
 rtl/proc_decode_pkg.sv | 38 +++
 rtl/vburst_seq.sv | 62 ++++++
 rtl/decode_stage_reg.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/proc_decode_pkg.sv
// Shared decode definitions: instruction field positions, type/opcode encodings
// and the vector-burst sequencer state type.
package proc_decode_pkg;

  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;
  localparam int OP_HI   = 29;
  localparam int OP_LO   = 25;
  localparam int RD_HI   = 24;
  localparam int RD_LO   = 20;
  localparam int RS1_HI  = 19;
  localparam int RS1_LO  = 15;
  localparam int RS2_HI  = 14;
  localparam int RS2_LO  = 10;
  localparam int IMM_HI  = 14;
  localparam int IMM_LO  = 0;

  localparam logic [1:0] TYPE_MEM = 2'b00;
  localparam logic [1:0] TYPE_ALU = 2'b01;

  localparam logic [4:0] OP_NOP      = 5'b00101;
  localparam logic [4:0] OP_STALL_RD = 5'b00110;
  localparam logic [4:0] OP_STALL_WR = 5'b00111;

  // opcode[4:3] selectors marking a memory op as a vector load / store
  localparam logic [1:0] VEC_LD_SEL = 2'b10;
  localparam logic [1:0] VEC_ST_SEL = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_VBURST = 1'b1
  } vburst_state_e;

  function automatic logic is_vec_mem(input logic [1:0] itype, input logic [4:0] op);
    return (itype == TYPE_MEM) && ((op[4:3] == VEC_LD_SEL) || (op[4:3] == VEC_ST_SEL));
  endfunction

endpackage

// File: rtl/vburst_seq.sv
// Vector-burst sequencer: IDLE/VBURST state register and beat counter.
//   state     | meaning
//   ST_IDLE   | presenting fetched instructions (or the last beat of a burst)
//   ST_VBURST | injecting beats; fetch is held
module vburst_seq
  import proc_decode_pkg::*;
#(
  parameter int VEC_LANES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_i,
  input  logic       flush_i,
  input  logic       start_i,
  output logic       in_burst_o,
  output logic [3:0] lane_o
);

  localparam logic [3:0] LAST_LANE = 4'(VEC_LANES - 1);

  vburst_state_e state_q, state_d;
  logic [3:0]    lane_q, lane_d;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      lane_d  = '0;
    end else if (!stall_i) begin
      case (state_q)
        ST_IDLE: begin
          lane_d = '0;
          if (start_i) state_d = ST_VBURST;
        end
        ST_VBURST: begin
          lane_d = lane_q + 4'd1;
          // leave on the edge that presents the final beat
          if ((lane_q + 4'd1) == LAST_LANE) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          lane_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  assign in_burst_o = (state_q == ST_VBURST);
  assign lane_o     = lane_q;

endmodule

// File: rtl/decode_stage_reg.sv
// Decode pipeline register with field split and optional vector-memory beat
// injection (enabled by macro DECODE_VBURST_EN).
module decode_stage_reg
  import proc_decode_pkg::*;
#(
  parameter int VEC_LANES = 4,
  parameter int IW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr_in,
  input  logic [31:0]   pc_in,
  input  logic          stall,
  input  logic          flush,
  output logic [1:0]    instruction_type,
  output logic [4:0]    opcode,
  output logic [4:0]    rd,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2,
  output logic [14:0]   imm,
  output logic [31:0]   pc_out,
  output logic          valid_out,
  output logic [3:0]    lane_idx,
  output logic          fetch_hold
);

  logic [1:0]  type_q, type_d;
  logic [4:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [14:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic        in_burst;
  logic [4:0]  beat_op;

`ifdef DECODE_VBURST_EN
  logic        vec_start;
  logic        vec_store_q;

  assign vec_start = !flush && !stall && !in_burst &&
                     is_vec_mem(instr_in[TYPE_HI:TYPE_LO], instr_in[OP_HI:OP_LO]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            vec_store_q <= 1'b0;
    else if (vec_start) vec_store_q <= (instr_in[OP_HI:OP_LO+3] == VEC_ST_SEL);
  end

  assign beat_op = vec_store_q ? OP_STALL_WR : OP_STALL_RD;

  vburst_seq #(
    .VEC_LANES (VEC_LANES)
  ) u_vburst_seq (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .flush_i    (flush),
    .start_i    (vec_start),
    .in_burst_o (in_burst),
    .lane_o     (lane_idx)
  );

  assign fetch_hold = in_burst;
`else
  assign in_burst   = 1'b0;
  assign beat_op    = OP_STALL_RD;
  assign lane_idx   = '0;
  assign fetch_hold = 1'b0;
`endif

  always_comb begin
    type_d  = type_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      type_d  = TYPE_ALU;
      op_d    = OP_NOP;
      rd_d    = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      imm_d   = '0;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (in_burst) begin
        // injected beat keeps the original operands and PC
        type_d  = TYPE_ALU;
        op_d    = beat_op;
        valid_d = 1'b1;
      end else begin
        type_d  = instr_in[TYPE_HI:TYPE_LO];
        op_d    = instr_in[OP_HI:OP_LO];
        rd_d    = instr_in[RD_HI:RD_LO];
        rs1_d   = instr_in[RS1_HI:RS1_LO];
        rs2_d   = instr_in[RS2_HI:RS2_LO];
        imm_d   = instr_in[IMM_HI:IMM_LO];
        pc_d    = pc_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q  <= TYPE_ALU;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      type_q  <= type_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instruction_type = type_q;
  assign opcode           = op_q;
  assign rd               = rd_q;
  assign rs1              = rs1_q;
  assign rs2              = rs2_q;
  assign imm              = imm_q;
  assign pc_out           = pc_q;
  assign valid_out        = valid_q;

endmodule
